// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller of the 16-bit RISC core:
// opcodes, sequencer states, decoded opcode classes and write-back mux codes.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU,
    CL_LI,
    CL_LD,
    CL_ST,
    CL_JMP,
    CL_HALT,
    CL_ILLEGAL
  } op_class_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

endpackage

// File: rtl/ctrl_if.sv
// Memory request/ready handshake between the controller (master) and the
// instruction/data memory (slave).
interface ctrl_if;

  logic [15:0] instr_in;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  instr_in,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output instr_in,
    output mem_ready
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: classifies an opcode and derives the ALU
// function; reserved opcodes D and E are reported as illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class,
  output logic [3:0] alu_op
);

  always_comb begin
    op_class = CL_NOP;
    alu_op   = 4'd0;
    case (opcode)
      OP_NOP: op_class = CL_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        op_class = CL_ALU;
        alu_op   = opcode;
      end
      OP_LI:   op_class = CL_LI;
      OP_LD:   op_class = CL_LD;
      OP_ST:   op_class = CL_ST;
      OP_JMP:  op_class = CL_JMP;
      OP_HALT: op_class = CL_HALT;
      default: op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle sequencer: fetches over the memory handshake, decodes, and
// steps the register file, ALU, load/store path and PC through each instruction.
module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  ctrl_if.master      mem,
  output logic        pc_en,
  output logic        pc_load,
  output logic [7:0]  imm,
  output logic        rf_en,
  output logic        rf_we,
  output logic [2:0]  sel_a,
  output logic [2:0]  sel_b,
  output logic [2:0]  sel_d,
  output logic [3:0]  alu_op,
  output logic        alu_en,
  output logic [1:0]  wb_src,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_cnt
);

  state_t      state;
  state_t      state_next;
  logic [15:0] ir;
  logic        ir_load;
  logic        retire;
  op_class_t   op_class;

  ctrl_decode u_decode (
    .opcode   (ir[15:12]),
    .op_class (op_class),
    .alu_op   (alu_op)
  );

  assign sel_d = ir[11:9];
  assign sel_a = ir[8:6];
  assign sel_b = ir[5:3];
  assign imm   = ir[7:0];

  // Reset clears ir too, so every ir-derived output reads zero in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ir        <= 16'd0;
      instr_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (ir_load) ir <= mem.instr_in;
      if (retire)  instr_cnt <= instr_cnt + 16'd1;
    end
  end

  always_comb begin
    state_next   = state;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    pc_en        = 1'b0;
    pc_load      = 1'b0;
    rf_en        = 1'b0;
    rf_we        = 1'b0;
    alu_en       = 1'b0;
    wb_src       = WB_ALU;
    halted       = 1'b0;
    illegal      = 1'b0;
    ir_load      = 1'b0;
    retire       = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        if (mem.mem_ready) begin
          ir_load    = 1'b1;
          pc_en      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        illegal    = (op_class == CL_ILLEGAL);
        state_next = (op_class == CL_HALT) ? S_HALT : S_READ;
      end
      S_READ: begin
        rf_en      = 1'b1;
        state_next = S_EXEC;
      end
      // Instructions with no memory or write-back phase retire straight from EXEC.
      S_EXEC: begin
        alu_en  = (op_class == CL_ALU);
        pc_load = (op_class == CL_JMP);
        case (op_class)
          CL_LD, CL_ST:  state_next = S_MEM;
          CL_ALU, CL_LI: state_next = S_WB;
          default: begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (op_class == CL_ST);
        if (mem.mem_ready) begin
          if (op_class == CL_LD) begin
            state_next = S_WB;
          end else begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_en  = 1'b1;
        rf_we  = 1'b1;
        wb_src = (op_class == CL_LD) ? WB_MEM :
                 (op_class == CL_LI) ? WB_IMM : WB_ALU;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed instruction table, multi-cycle
// corner sequences, and a randomized run against a phase-queue model.
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en, pc_load, rf_en, rf_we, alu_en, halted, illegal;
  logic [7:0]  imm;
  logic [2:0]  sel_a, sel_b, sel_d;
  logic [3:0]  alu_op;
  logic [1:0]  wb_src;
  logic [15:0] instr_cnt;

  int checks   = 0;
  int failures = 0;

  ctrl_if mem_bus ();

  ctrl_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (mem_bus),
    .pc_en     (pc_en),
    .pc_load   (pc_load),
    .imm       (imm),
    .rf_en     (rf_en),
    .rf_we     (rf_we),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .sel_d     (sel_d),
    .alu_op    (alu_op),
    .alu_en    (alu_en),
    .wb_src    (wb_src),
    .halted    (halted),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        pc_en;
    logic        pc_load;
    logic [7:0]  imm;
    logic        rf_en;
    logic        rf_we;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic [2:0]  sel_d;
    logic [3:0]  alu_op;
    logic        alu_en;
    logic [1:0]  wb_src;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_cnt;
  } outs_t;

  typedef struct {
    logic [15:0] instr;
    int fetch_wait, mem_wait;
    int exp_cycles, exp_rf_we, exp_ill, exp_pc_load, exp_mem_we, exp_mem_cycles;
    int exp_wb_src;
  } vec_t;

  typedef struct {
    int cycles, rf_we_n, ill_n, pc_load_n, mem_we_n, mem_cycles;
    int wb_src_seen, alu_op_seen, imm_seen, sel_seen;
    bit done;
  } obs_t;

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_READ, P_EXEC, P_MEM, P_WB, P_HALT} phase_t;

  phase_t      plan[$];
  logic [15:0] m_ir;
  logic [15:0] m_cnt;

  function automatic outs_t dut_outs();
    outs_t o;
    o.mem_req = mem_bus.mem_req;  o.mem_we = mem_bus.mem_we;  o.addr_sel = mem_bus.addr_sel;
    o.pc_en = pc_en;  o.pc_load = pc_load;  o.imm = imm;  o.rf_en = rf_en;  o.rf_we = rf_we;
    o.sel_a = sel_a;  o.sel_b = sel_b;  o.sel_d = sel_d;  o.alu_op = alu_op;  o.alu_en = alu_en;
    o.wb_src = wb_src;  o.halted = halted;  o.illegal = illegal;  o.instr_cnt = instr_cnt;
    return o;
  endfunction

  function automatic logic [3:0] exp_alu_op(logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd8) ? op : 4'd0;
  endfunction

  // Expected outputs for one cycle, from the phase being executed and the latched instruction.
  function automatic outs_t model_outs(phase_t ph, logic [15:0] ir, logic rdy, logic [15:0] cnt);
    outs_t o;
    logic [3:0] op;
    o = '0;
    op = ir[15:12];
    o.sel_d = ir[11:9];  o.sel_a = ir[8:6];  o.sel_b = ir[5:3];  o.imm = ir[7:0];
    o.alu_op = exp_alu_op(op);
    o.instr_cnt = cnt;
    case (ph)
      P_FETCH:  begin o.mem_req = 1'b1; o.addr_sel = 1'b1; o.pc_en = rdy; end
      P_DECODE: o.illegal = (op == 4'hD || op == 4'hE);
      P_READ:   o.rf_en = 1'b1;
      P_EXEC:   begin o.alu_en = (op >= 4'd1 && op <= 4'd8); o.pc_load = (op == 4'hC); end
      P_MEM:    begin o.mem_req = 1'b1; o.mem_we = (op == 4'hB); end
      P_WB: begin
        o.rf_en = 1'b1;  o.rf_we = 1'b1;
        o.wb_src = (op == 4'hA) ? 2'd2 : (op == 4'h9) ? 2'd1 : 2'd0;
      end
      P_HALT:   o.halted = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

  task automatic build_plan(input logic [3:0] op);
    plan.delete();
    plan.push_back(P_DECODE);
    if (op == 4'hF) begin
      plan.push_back(P_HALT);
    end else begin
      plan.push_back(P_READ);
      plan.push_back(P_EXEC);
      if (op == 4'hA || op == 4'hB) plan.push_back(P_MEM);
      if ((op >= 4'd1 && op <= 4'd9) || op == 4'hA) plan.push_back(P_WB);
    end
  endtask

  task automatic finish_phase();
    void'(plan.pop_front());
    if (plan.size() == 0) begin
      m_cnt = m_cnt + 16'd1;
      plan.push_back(P_FETCH);
    end
  endtask

  task automatic model_step(input logic rst_low, input logic rdy, input logic [15:0] instr);
    if (rst_low) begin
      plan.delete();
      plan.push_back(P_IDLE);
      m_ir  = 16'd0;
      m_cnt = 16'd0;
    end else begin
      case (plan[0])
        P_IDLE:  begin plan.delete(); plan.push_back(P_FETCH); end
        P_FETCH: if (rdy) begin m_ir = instr; build_plan(instr[15:12]); end
        P_MEM:   if (rdy) finish_phase();
        P_HALT:  ;
        default: finish_phase();
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    rst_n = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.instr_in  = 16'h1250;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    mem_bus.mem_ready = 1'b0;
    #1;
  endtask

  // Runs one instruction starting from FETCH, acting as memory, until instr_cnt moves.
  task automatic applyStimulus(input logic [15:0] instr, input int fetch_wait, input int mem_wait,
                               input logic [15:0] cnt_before, output obs_t o);
    int fw, mw;
    fw = fetch_wait;
    mw = mem_wait;
    o = '{default: 0};
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      mem_bus.instr_in  = instr;
      mem_bus.mem_ready = 1'b0;
      #1;
      if (instr_cnt != cnt_before) begin
        o.done = 1'b1;
        break;
      end
      if (mem_bus.mem_req && mem_bus.addr_sel) begin
        if (fw == 0) mem_bus.mem_ready = 1'b1; else fw--;
      end else if (mem_bus.mem_req) begin
        o.mem_cycles++;
        if (mem_bus.mem_we) o.mem_we_n++;
        if (mw == 0) mem_bus.mem_ready = 1'b1; else mw--;
      end
      #1;
      o.cycles++;
      if (rf_we)   begin o.rf_we_n++; o.wb_src_seen = int'(wb_src); end
      if (illegal) o.ill_n++;
      if (pc_load) begin o.pc_load_n++; o.imm_seen = int'(imm); end
      if (alu_en)  o.alu_op_seen = int'(alu_op);
      o.sel_seen = int'({sel_d, sel_a, sel_b});
    end
    mem_bus.mem_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[13];
    obs_t        ob;
    logic [15:0] exp_cnt;
    logic [15:0] rin;
    logic        rrdy, rrst;
    outs_t       exp_o;
    int          rf_we_seen, halt_at, halt_cycles, req_after, ill_seen;

    vecs[0]  = '{16'h1250, 0, 0, 5, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{16'h1250, 2, 0, 7, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{16'h9305, 0, 0, 5, 1, 0, 0, 0, 0, 1};
    vecs[3]  = '{16'hA280, 0, 3, 9, 1, 0, 0, 0, 4, 2};
    vecs[4]  = '{16'hA280, 0, 0, 6, 1, 0, 0, 0, 1, 2};
    vecs[5]  = '{16'hB0D8, 0, 0, 5, 0, 0, 0, 1, 1, 0};
    vecs[6]  = '{16'hB0D8, 0, 2, 7, 0, 0, 0, 3, 3, 0};
    vecs[7]  = '{16'hC042, 0, 0, 4, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{16'h0000, 0, 0, 4, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{16'hD000, 0, 0, 4, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{16'hE1FF, 0, 0, 4, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{16'h8AC0, 0, 0, 5, 1, 0, 0, 0, 0, 0};
    vecs[12] = '{16'h6AC0, 1, 0, 6, 1, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.instr_in  = 16'h0000;

    reset_dut();
    checkOutput("reset_outputs", 64'(dut_outs()), 64'd0);

    exp_cnt = 16'd0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].fetch_wait, vecs[i].mem_wait, exp_cnt, ob);
      exp_cnt = exp_cnt + 16'd1;
      checkOutput($sformatf("v%0d_retired", i), 64'(ob.done), 64'd1);
      checkOutput($sformatf("v%0d_instr_cnt", i), 64'(instr_cnt), 64'(exp_cnt));
      checkOutput($sformatf("v%0d_cycles", i), 64'(ob.cycles), 64'(vecs[i].exp_cycles));
      checkOutput($sformatf("v%0d_rf_we", i), 64'(ob.rf_we_n), 64'(vecs[i].exp_rf_we));
      checkOutput($sformatf("v%0d_illegal", i), 64'(ob.ill_n), 64'(vecs[i].exp_ill));
      checkOutput($sformatf("v%0d_pc_load", i), 64'(ob.pc_load_n), 64'(vecs[i].exp_pc_load));
      checkOutput($sformatf("v%0d_mem_we", i), 64'(ob.mem_we_n), 64'(vecs[i].exp_mem_we));
      checkOutput($sformatf("v%0d_mem_cycles", i), 64'(ob.mem_cycles), 64'(vecs[i].exp_mem_cycles));
      checkOutput($sformatf("v%0d_wb_src", i), 64'(ob.wb_src_seen), 64'(vecs[i].exp_wb_src));
      checkOutput($sformatf("v%0d_alu_op", i), 64'(ob.alu_op_seen),
                  64'(exp_alu_op(vecs[i].instr[15:12])));
      checkOutput($sformatf("v%0d_sel", i), 64'(ob.sel_seen), 64'(vecs[i].instr[11:3]));
      checkOutput($sformatf("v%0d_imm_at_load", i), 64'(ob.imm_seen),
                  (vecs[i].instr[15:12] == 4'hC) ? 64'(vecs[i].instr[7:0]) : 64'd0);
    end

    // Reset while an LD waits in MEM with mem_ready arriving in the same cycle.
    rf_we_seen = 0;
    ob.done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      mem_bus.instr_in  = 16'hA280;
      mem_bus.mem_ready = 1'b0;
      #1;
      if (rf_we) rf_we_seen++;
      if (mem_bus.mem_req && mem_bus.addr_sel) mem_bus.mem_ready = 1'b1;
      if (mem_bus.mem_req && !mem_bus.addr_sel) begin
        ob.done = 1'b1;
        break;
      end
    end
    checkOutput("rst_mem_reached", 64'(ob.done), 64'd1);
    rst_n = 1'b0;
    mem_bus.mem_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    mem_bus.mem_ready = 1'b0;
    #1;
    checkOutput("rst_mem_outputs", 64'(dut_outs()), 64'd0);
    if (rf_we) rf_we_seen++;
    @(posedge clk); #3;
    if (rf_we) rf_we_seen++;
    checkOutput("rst_mem_no_wb", 64'(rf_we_seen), 64'd0);
    checkOutput("rst_mem_refetch", 64'({mem_bus.mem_req, mem_bus.addr_sel, pc_en}), 64'b110);

    // Randomized run against the phase-queue model, with occasional resets.
    reset_dut();
    plan.delete();
    plan.push_back(P_FETCH);
    m_ir  = 16'd0;
    m_cnt = 16'd0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      rin = {4'($urandom_range(0, 14)), 12'($urandom)};
      rrdy = 1'($urandom);
      rrst = ($urandom_range(0, 63) == 0);
      mem_bus.instr_in  = rin;
      mem_bus.mem_ready = rrdy;
      rst_n = !rrst;
      #1;
      exp_o = model_outs(plan[0], m_ir, rrdy, m_cnt);
      checkOutput($sformatf("rand_c%0d_outs", c), 64'(dut_outs()), 64'(exp_o));
      model_step(rrst, rrdy, rin);
    end
    rst_n = 1'b1;

    // HALT holds forever despite further mem_ready pulses.
    reset_dut();
    halt_at = -1;
    halt_cycles = 0;
    req_after = 0;
    ill_seen = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #2;
      mem_bus.instr_in  = 16'hF000;
      mem_bus.mem_ready = (c == 0) ? 1'b1 : 1'(c % 2);
      #1;
      if (halted && halt_at < 0) halt_at = c;
      if (c >= 2) begin
        if (halted) halt_cycles++;
        if (mem_bus.mem_req) req_after++;
      end
      if (illegal) ill_seen++;
    end
    mem_bus.mem_ready = 1'b0;
    checkOutput("halt_first_cycle", 64'(halt_at), 64'd2);
    checkOutput("halt_held", 64'(halt_cycles), 64'd43);
    checkOutput("halt_no_mem_req", 64'(req_after), 64'd0);
    checkOutput("halt_no_illegal", 64'(ill_seen), 64'd0);
    checkOutput("halt_instr_cnt", 64'(instr_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
